// File: rtl/cfg_ctrl_pkg.sv
// rtl/cfg_ctrl_pkg.sv - state encoding and word-count helper shared by the config loader
package cfg_ctrl_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_VERIFY = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_ERROR  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_LOAD   = S_LOAD,
      ST_VERIFY = S_VERIFY,
      ST_DONE   = S_DONE,
      ST_ERROR  = S_ERROR
   } state_t;

   function automatic int words_needed(input int config_width, input int word_width);
      return (config_width + word_width - 1) / word_width;
   endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// rtl/cfg_word_serializer.sv - turns bitstream words into an LSB-first bit stream for one pass
module cfg_word_serializer
   import cfg_ctrl_pkg::*;
#(
   parameter int CONFIG_WIDTH = 64,
   parameter int WORD_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  busy,
   input  logic [WORD_WIDTH-1:0] cfg_word,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   output logic                  bit_valid,
   output logic                  bit_data
);

   localparam int WORDS = words_needed(CONFIG_WIDTH, WORD_WIDTH);
   localparam int REM   = CONFIG_WIDTH % WORD_WIDTH;
   localparam int BLW   = $clog2(WORD_WIDTH + 1);
   localparam int WCW   = $clog2(WORDS + 1);
   localparam logic [BLW-1:0] FULL_BITS = BLW'(WORD_WIDTH);
   localparam logic [BLW-1:0] LAST_BITS = (REM == 0) ? FULL_BITS : BLW'(REM);

   logic [WORD_WIDTH-1:0] shreg;
   logic [BLW-1:0]        bits_left;
   logic [WCW-1:0]        words_acc;
   logic                  take;

   assign bit_valid = busy && (bits_left != '0);
   assign bit_data  = shreg[0];
   // Accepting on the last remaining bit lets the next word follow without a bubble
   assign cfg_ready = busy && (bits_left <= BLW'(1)) && (words_acc < WCW'(WORDS));
   assign take      = cfg_valid && cfg_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg     <= '0;
         bits_left <= '0;
         words_acc <= '0;
      end else if (clear) begin
         bits_left <= '0;
         words_acc <= '0;
      end else if (take) begin
         shreg     <= cfg_word;
         bits_left <= (words_acc == WCW'(WORDS - 1)) ? LAST_BITS : FULL_BITS;
         words_acc <= words_acc + WCW'(1);
      end else if (bit_valid) begin
         shreg     <= shreg >> 1;
         bits_left <= bits_left - BLW'(1);
      end
   end

endmodule

// File: rtl/config_load_ctrl.sv
// rtl/config_load_ctrl.sv - loads the fabric config chain, re-shifts it to verify, then enables the fabric
module config_load_ctrl
   import cfg_ctrl_pkg::*;
#(
   parameter int CONFIG_WIDTH = 64,
   parameter int WORD_WIDTH   = 8,
   parameter int ERR_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WORD_WIDTH-1:0] cfg_word,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   output logic                  config_in,
   output logic                  config_shift_en,
   input  logic                  config_out,
   output logic                  pass,
   output logic                  busy,
   output logic                  config_done,
   output logic                  config_error,
   output logic [ERR_WIDTH-1:0]  err_count,
   output logic                  fabric_en
);

   localparam int BCW = $clog2(CONFIG_WIDTH + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(CONFIG_WIDTH - 1);

   state_t               state, next_state;
   logic [BCW-1:0]       bit_cnt;
   logic                 last_shift;
   logic                 mismatch;
   logic                 pass_change;
   logic [ERR_WIDTH-1:0] err_next;

   cfg_word_serializer #(
      .CONFIG_WIDTH (CONFIG_WIDTH),
      .WORD_WIDTH   (WORD_WIDTH)
   ) u_ser (
      .clk       (clk),
      .rst       (rst),
      .clear     (pass_change),
      .busy      (busy),
      .cfg_word  (cfg_word),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .bit_valid (config_shift_en),
      .bit_data  (config_in)
   );

   assign last_shift  = config_shift_en && (bit_cnt == LAST_BIT);
   assign mismatch    = (state == ST_VERIFY) && config_shift_en && (config_out != config_in);
   assign err_next    = (mismatch && (err_count != '1)) ? err_count + ERR_WIDTH'(1) : err_count;
   assign pass_change = (next_state != state);

   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) next_state = ST_LOAD;
            ST_LOAD:   if (last_shift) next_state = ST_VERIFY;
            ST_VERIFY: if (last_shift) next_state = (err_next == '0) ? ST_DONE : ST_ERROR;
            default:   next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         err_count    <= '0;
         busy         <= 1'b0;
         pass         <= 1'b0;
         config_done  <= 1'b0;
         config_error <= 1'b0;
         fabric_en    <= 1'b0;
      end else begin
         state <= next_state;
         if (pass_change) bit_cnt <= '0;
         else if (config_shift_en) bit_cnt <= bit_cnt + BCW'(1);
         // Abort freezes the count so the partial verify result stays visible
         if (next_state == ST_LOAD && state != ST_LOAD) err_count <= '0;
         else if (!abort) err_count <= err_next;
         busy         <= (next_state == ST_LOAD) || (next_state == ST_VERIFY);
         pass         <= (next_state == ST_VERIFY) || (next_state == ST_DONE) ||
                         (next_state == ST_ERROR);
         config_done  <= (next_state == ST_DONE);
         config_error <= (next_state == ST_ERROR);
         fabric_en    <= (next_state == ST_DONE);
      end
   end

endmodule

// File: tb/tb_config_load_ctrl.sv
// tb/tb_config_load_ctrl.sv - randomized load/verify bench for config_load_ctrl against a bitstream model
module tb_config_load_ctrl;

   localparam int BUDGET = 400;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0] start_v, abort_v, cfg_valid_v, ready_v, config_in_v, shift_en_v, cfg_out_v;
   logic [1:0] pass_v, busy_v, done_v, error_v, fabric_v;
   logic [7:0]  cfg_word_v [2];
   logic [15:0] err0;
   logic [2:0]  err1;
   logic [15:0] err_v [2];
   logic [15:0] chain0 = '0;
   logic [11:0] chain1 = '0;
   logic [15:0] chain_v [2];

   logic [7:0] words [4];
   int widx, shift_cnt;
   int n_tests = 0;
   int n_fail = 0;

   config_load_ctrl #(.CONFIG_WIDTH(16), .WORD_WIDTH(8), .ERR_WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
      .cfg_word(cfg_word_v[0]), .cfg_valid(cfg_valid_v[0]), .cfg_ready(ready_v[0]),
      .config_in(config_in_v[0]), .config_shift_en(shift_en_v[0]), .config_out(cfg_out_v[0]),
      .pass(pass_v[0]), .busy(busy_v[0]), .config_done(done_v[0]), .config_error(error_v[0]),
      .err_count(err0), .fabric_en(fabric_v[0]));

   config_load_ctrl #(.CONFIG_WIDTH(12), .WORD_WIDTH(8), .ERR_WIDTH(3)) u_dut12 (
      .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
      .cfg_word(cfg_word_v[1]), .cfg_valid(cfg_valid_v[1]), .cfg_ready(ready_v[1]),
      .config_in(config_in_v[1]), .config_shift_en(shift_en_v[1]), .config_out(cfg_out_v[1]),
      .pass(pass_v[1]), .busy(busy_v[1]), .config_done(done_v[1]), .config_error(error_v[1]),
      .err_count(err1), .fabric_en(fabric_v[1]));

   // Config chains: head at the MSB, tail at bit 0
   always @(posedge clk) begin
      if (shift_en_v[0]) chain0 <= {config_in_v[0], chain0[15:1]};
      if (shift_en_v[1]) chain1 <= {config_in_v[1], chain1[11:1]};
   end
   assign cfg_out_v  = {chain1[0], chain0[0]};
   assign chain_v[0] = chain0;
   assign chain_v[1] = {4'd0, chain1};
   assign err_v[0]   = err0;
   assign err_v[1]   = {13'd0, err1};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Load words are words[0..1], verify words are words[2..3]
   function automatic int partial_mism(input int n);
      int m;
      m = 0;
      for (int i = 0; i < n; i++)
         if (words[i / 8][i % 8] != words[2 + i / 8][i % 8]) m++;
      return m;
   endfunction

   task automatic set_words(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
      words[0] = a; words[1] = b; words[2] = c; words[3] = d;
   endtask

   task automatic tick(input int s);
      if (shift_en_v[s]) shift_cnt++;
      if (cfg_valid_v[s] && ready_v[s]) widx++;
      @(posedge clk);
      #1;
      cfg_word_v[s] = (widx < 4) ? words[widx] : 8'h00;
   endtask

   task automatic begin_run(input int s);
      widx = 0;
      shift_cnt = 0;
      cfg_word_v[s] = words[0];
      cfg_valid_v[s] = 1'b0;
      start_v[s] = 1'b1;
      tick(s);
      start_v[s] = 1'b0;
   endtask

   task automatic advance(input int s, input bit gaps, input int stop_shift, input int restart_at);
      int cyc;
      cyc = 0;
      while (!done_v[s] && !error_v[s] && shift_cnt < stop_shift && cyc < BUDGET) begin
         cfg_valid_v[s] = gaps ? 1'(cyc % 2) : 1'b1;
         start_v[s] = (shift_cnt == restart_at);
         tick(s);
         cyc++;
      end
      start_v[s] = 1'b0;
      cfg_valid_v[s] = 1'b0;
      check_eq("run_bounded", 32'(cyc < BUDGET), 32'd1);
   endtask

   task automatic check_result(input int s, input string tag);
      int cw, maxe, mism;
      logic [15:0] vbits;
      cw = (s == 0) ? 16 : 12;
      maxe = (s == 0) ? 65535 : 7;
      vbits = '0;
      for (int i = 0; i < cw; i++) vbits[i] = words[2 + i / 8][i % 8];
      mism = partial_mism(cw);
      if (mism > maxe) mism = maxe;
      check_eq({tag, "_shifts"}, shift_cnt, 2 * cw);
      check_eq({tag, "_done"}, done_v[s], 32'(mism == 0));
      check_eq({tag, "_error"}, error_v[s], 32'(mism != 0));
      check_eq({tag, "_fabric"}, fabric_v[s], 32'(mism == 0));
      check_eq({tag, "_err"}, err_v[s], mism);
      check_eq({tag, "_pass"}, pass_v[s], 1);
      check_eq({tag, "_busy"}, busy_v[s], 0);
      check_eq({tag, "_chain"}, chain_v[s], vbits);
   endtask

   task automatic run_full(input int s, input bit gaps, input int restart_at, input string tag);
      begin_run(s);
      advance(s, gaps, 1000, restart_at);
      check_result(s, tag);
   endtask

   task automatic check_idle_outputs(input int s, input string tag);
      check_eq({tag, "_busy"}, busy_v[s], 0);
      check_eq({tag, "_pass"}, pass_v[s], 0);
      check_eq({tag, "_done"}, done_v[s], 0);
      check_eq({tag, "_error"}, error_v[s], 0);
      check_eq({tag, "_fabric"}, fabric_v[s], 0);
      check_eq({tag, "_shift_en"}, shift_en_v[s], 0);
      check_eq({tag, "_ready"}, ready_v[s], 0);
   endtask

   initial begin
      start_v = '0; abort_v = '0; cfg_valid_v = '0;
      cfg_word_v[0] = '0; cfg_word_v[1] = '0;
      set_words(8'h00, 8'h00, 8'h00, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check_idle_outputs(s, "reset");
         check_eq("reset_err", err_v[s], 0);
         check_eq("reset_config_in", config_in_v[s], 0);
      end
      rst = 1'b0;

      set_words(8'hA5, 8'h3C, 8'hA5, 8'h3C);
      run_full(0, 1'b0, -1, "clean16");
      set_words(8'hA5, 8'h3C, 8'hA5, 8'h3D);
      run_full(0, 1'b0, -1, "bad16");
      set_words(8'hFF, 8'h0F, 8'hFF, 8'h0F);
      run_full(1, 1'b0, -1, "clean12");
      run_full(1, 1'b1, -1, "gaps12");
      set_words(8'h00, 8'h00, 8'hFF, 8'hFF);
      run_full(1, 1'b0, -1, "sat12");

      // Abort mid-load, then a fresh clean load
      set_words(8'hA5, 8'h3C, 8'hA5, 8'h3C);
      begin_run(0);
      advance(0, 1'b0, 5, -1);
      check_eq("abort_at_bit", shift_cnt, 5);
      abort_v[0] = 1'b1; tick(0); abort_v[0] = 1'b0;
      check_idle_outputs(0, "abort_load");
      run_full(0, 1'b0, -1, "after_abort");
      abort_v[0] = 1'b1; tick(0); abort_v[0] = 1'b0;
      check_idle_outputs(0, "abort_done");

      // Abort mid-verify keeps the mismatch count; abort beats start
      set_words(8'hA5, 8'h3C, 8'h5A, 8'h3C);
      begin_run(0);
      advance(0, 1'b0, 20, -1);
      abort_v[0] = 1'b1; tick(0); abort_v[0] = 1'b0;
      check_idle_outputs(0, "abort_verify");
      check_eq("abort_verify_err", err_v[0], partial_mism(4));
      abort_v[0] = 1'b1; start_v[0] = 1'b1; tick(0);
      abort_v[0] = 1'b0; start_v[0] = 1'b0;
      check_idle_outputs(0, "abort_and_start");
      check_eq("abort_and_start_err", err_v[0], partial_mism(4));

      // start while busy is ignored
      set_words(8'h96, 8'hC3, 8'h96, 8'hC3);
      run_full(1, 1'b0, 7, "start_busy12");
      run_full(0, 1'b1, 21, "start_busy16");

      for (int it = 0; it < 20; it++) begin
         int s, restart;
         bit gaps;
         s = $urandom_range(0, 1);
         gaps = 1'($urandom_range(0, 1));
         restart = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
         words[0] = 8'($urandom);
         words[1] = 8'($urandom);
         words[2] = ($urandom_range(0, 1) == 0) ? words[0] : 8'($urandom);
         words[3] = ($urandom_range(0, 1) == 0) ? words[1] : 8'($urandom);
         run_full(s, gaps, restart, "rand");
      end

      // Asynchronous reset between edges during verify
      set_words(8'hA5, 8'h3C, 8'h5A, 8'h3C);
      begin_run(0);
      advance(0, 1'b0, 19, -1);
      check_eq("pre_reset_err", err_v[0], partial_mism(3));
      #2 rst = 1'b1;
      #1;
      check_idle_outputs(0, "async_reset");
      check_eq("async_reset_err", err_v[0], 0);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      check_idle_outputs(0, "post_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
